// File: rtl/dac_pkg.sv
// Shared definitions for the DAC write scheduler: I2C address/command
// encodings, FSM state encoding and the 32-bit frame layout handed to the
// I2C frame engine.
package dac_pkg;

  localparam logic [7:0]  SLAVE_ADDR_DEF   = 8'hC0;
  localparam logic [2:0]  CMD_WRITE_DAC    = 3'b010;
  localparam logic [2:0]  CMD_WRITE_DAC_EE = 3'b011;
  localparam int unsigned TIMER_W          = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_RUN     = 3'd2,
    ST_EE_WAIT = 3'd3,
    ST_ABORT   = 3'd4
  } state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] cmd;
    logic [7:0] data_hi;
    logic [7:0] data_lo;
  } frame_t;

  // Command byte: C2:C0, two reserved zeros, PD1:PD0, trailing zero.
  function automatic logic [7:0] cmd_byte(input logic [2:0] cmd, input logic [1:0] pd);
    return {cmd, 2'b00, pd, 1'b0};
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate tick generator.
// Ports: CLOCK_50 / iRST_N - clock and async active-low reset;
//        tick - one-cycle pulse each time the 0..DIV-1 counter wraps.
module sample_tick_gen #(
  parameter int unsigned DIV = 6250
) (
  input  logic CLOCK_50,
  input  logic iRST_N,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  // Free-running divider; tick is registered so it is glitch-free.
  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CNT_W'(DIV - 1));
      if (cnt == CNT_W'(DIV - 1)) cnt <= '0;
      else                        cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dac_write_scheduler.sv
// Schedules every write to an MCP4725-class DAC over the shared I2C frame
// engine: periodic sample frames, host power-down config writes and
// EEPROM writes, with a post-EEPROM lockout and END-edge timeouts.
// Ports:
//   CLOCK_50, iRST_N         - clock, async active-low reset
//   audio_in_signed[15:0]    - signed sample, captured on the sample tick
//   cfg_req, pd_mode[1:0]    - power-down config write request and mode
//   ee_req                   - DAC+EEPROM write request
//   i2c_end, i2c_ack         - engine END (1 = idle/done) and ACK (1 = NACK)
//   i2c_data[31:0], i2c_go   - frame {addr, cmd, data_hi, data_lo} and request
//   busy                     - FSM outside IDLE
//   drop_cnt[15:0]           - saturating count of overrun sample ticks
//   nack_err, timeout_err    - sticky error flags
module dac_write_scheduler
  import dac_pkg::*;
#(
  parameter int unsigned CLK_Freq       = 50_000_000,
  parameter int unsigned SAMPLE_RATE    = 8_000,
  parameter logic [7:0]  SLAVE_ADDR     = SLAVE_ADDR_DEF,
  parameter int unsigned EE_WAIT_CYCLES = 2_500_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        CLOCK_50,
  input  logic        iRST_N,
  input  logic [15:0] audio_in_signed,
  input  logic        cfg_req,
  input  logic [1:0]  pd_mode,
  input  logic        ee_req,
  input  logic        i2c_end,
  input  logic        i2c_ack,
  output logic [31:0] i2c_data,
  output logic        i2c_go,
  output logic        busy,
  output logic [15:0] drop_cnt,
  output logic        nack_err,
  output logic        timeout_err
);

  localparam int unsigned DIV = CLK_Freq / SAMPLE_RATE;

  logic               end_m, end_s, ack_m, ack_s;
  logic               tick;
  state_t             state, state_d;
  frame_t             data_q, data_d;
  logic               go_d, nack_d, to_d, is_ee_q, is_ee_d;
  logic [TIMER_W-1:0] timer, timer_d;
  logic               samp_pend, cfg_pend, ee_pend;
  logic [1:0]         pd_reg;
  logic [11:0]        held12;
  logic               launch_ee_c, launch_cfg_c, launch_samp_c;
  logic               unused_audio_lsbs;

  assign unused_audio_lsbs = ^audio_in_signed[3:0];
  assign i2c_data          = data_q;

  sample_tick_gen #(.DIV(DIV)) u_tick (
    .CLOCK_50 (CLOCK_50),
    .iRST_N   (iRST_N),
    .tick     (tick)
  );

  // END/ACK come from the engine's domain: two-flop synchronisers.
  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      end_m <= 1'b0;
      end_s <= 1'b0;
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      end_m <= i2c_end;
      end_s <= end_m;
      ack_m <= i2c_ack;
      ack_s <= ack_m;
    end
  end

  // Pending requests, held sample and overrun counter.
  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      samp_pend <= 1'b0;
      cfg_pend  <= 1'b0;
      ee_pend   <= 1'b0;
      pd_reg    <= 2'b00;
      held12    <= 12'h800;
      drop_cnt  <= '0;
    end else begin
      // Offset-binary conversion: adding 32768 only flips the sign bit.
      if (tick) begin
        held12    <= {~audio_in_signed[15], audio_in_signed[14:4]};
        samp_pend <= 1'b1;
        if (samp_pend && !launch_samp_c && drop_cnt != 16'hFFFF)
          drop_cnt <= drop_cnt + 16'd1;
      end else if (launch_samp_c) begin
        samp_pend <= 1'b0;
      end

      if (cfg_req) begin
        cfg_pend <= 1'b1;
        pd_reg   <= pd_mode;
      end else if (launch_cfg_c) begin
        cfg_pend <= 1'b0;
      end

      if (ee_req)           ee_pend <= 1'b1;
      else if (launch_ee_c) ee_pend <= 1'b0;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      state       <= ST_IDLE;
      data_q      <= '0;
      i2c_go      <= 1'b0;
      busy        <= 1'b0;
      nack_err    <= 1'b0;
      timeout_err <= 1'b0;
      timer       <= '0;
      is_ee_q     <= 1'b0;
    end else begin
      state       <= state_d;
      data_q      <= data_d;
      i2c_go      <= go_d;
      busy        <= (state_d != ST_IDLE);
      nack_err    <= nack_d;
      timeout_err <= to_d;
      timer       <= timer_d;
      is_ee_q     <= is_ee_d;
    end
  end

  // Next-state logic; timer counts cycles spent in the current state.
  always_comb begin
    state_d       = state;
    data_d        = data_q;
    go_d          = i2c_go;
    nack_d        = nack_err;
    to_d          = timeout_err;
    timer_d       = timer + TIMER_W'(1);
    is_ee_d       = is_ee_q;
    launch_ee_c   = 1'b0;
    launch_cfg_c  = 1'b0;
    launch_samp_c = 1'b0;

    unique case (state)
      ST_IDLE: begin
        timer_d = '0;
        if (end_s && (ee_pend || cfg_pend || samp_pend)) begin
          launch_ee_c    = ee_pend;
          launch_cfg_c   = !ee_pend && cfg_pend;
          launch_samp_c  = !ee_pend && !cfg_pend;
          data_d.addr    = SLAVE_ADDR;
          data_d.cmd     = cmd_byte(ee_pend ? CMD_WRITE_DAC_EE : CMD_WRITE_DAC, pd_reg);
          data_d.data_hi = held12[11:4];
          data_d.data_lo = {held12[3:0], 4'b0000};
          is_ee_d        = ee_pend;
          go_d           = 1'b1;
          state_d        = ST_REQ;
        end
      end

      ST_REQ: begin
        if (!end_s) begin
          state_d = ST_RUN;
          timer_d = '0;
        end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_ABORT;
          go_d    = 1'b0;
          to_d    = 1'b1;
        end
      end

      ST_RUN: begin
        if (end_s) begin
          go_d    = 1'b0;
          nack_d  = nack_err | ack_s;
          timer_d = '0;
          state_d = is_ee_q ? ST_EE_WAIT : ST_IDLE;
        end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_ABORT;
          go_d    = 1'b0;
          to_d    = 1'b1;
        end
      end

      ST_EE_WAIT: begin
        if (timer == TIMER_W'(EE_WAIT_CYCLES - 1)) state_d = ST_IDLE;
      end

      ST_ABORT: begin
        go_d = 1'b0;
        to_d = 1'b1;
        if (end_s) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dac_write_scheduler.sv
`timescale 1ns/1ps
module tb_dac_write_scheduler;

  logic        CLOCK_50 = 1'b0;
  logic        iRST_N;
  logic [15:0] audio_in_signed;
  logic        cfg_req, ee_req;
  logic [1:0]  pd_mode;
  logic        i2c_end, i2c_ack;
  logic [31:0] i2c_data;
  logic        i2c_go, busy, nack_err, timeout_err;
  logic [15:0] drop_cnt;

  // Divisor 100, short lockout and timeout keep the run small.
  dac_write_scheduler #(
    .CLK_Freq       (50_000_000),
    .SAMPLE_RATE    (500_000),
    .SLAVE_ADDR     (8'hC0),
    .EE_WAIT_CYCLES (300),
    .TIMEOUT_CYCLES (500)
  ) dut (
    .CLOCK_50        (CLOCK_50),
    .iRST_N          (iRST_N),
    .audio_in_signed (audio_in_signed),
    .cfg_req         (cfg_req),
    .pd_mode         (pd_mode),
    .ee_req          (ee_req),
    .i2c_end         (i2c_end),
    .i2c_ack         (i2c_ack),
    .i2c_data        (i2c_data),
    .i2c_go          (i2c_go),
    .busy            (busy),
    .drop_cnt        (drop_cnt),
    .nack_err        (nack_err),
    .timeout_err     (timeout_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Engine model: records each frame, then END low for rsp_n_low cycles.
  logic [31:0] frames[$];
  int          frame_cyc[$];
  int          rsp_low    = 3;
  int          rsp_n_low  = 3;
  logic        rsp_ack    = 1'b0;
  logic        rsp_ignore = 1'b0;
  int          rsp_done   = 0;

  initial begin
    i2c_end = 1'b1;
    i2c_ack = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      if (i2c_go && !rsp_ignore && iRST_N) begin
        rsp_n_low = rsp_low;
        frames.push_back(i2c_data);
        frame_cyc.push_back(cyc);
        repeat (2) @(negedge CLOCK_50);
        i2c_end = 1'b0;
        repeat (rsp_n_low) @(negedge CLOCK_50);
        i2c_ack = rsp_ack;
        i2c_end = 1'b1;
        for (int i = 0; i < 20 && i2c_go; i++) @(negedge CLOCK_50);
        i2c_ack = 1'b0;
        rsp_done++;
      end
    end
  end

  task automatic wait_frames(input int n, input int budget, input string tag);
    int k = 0;
    while (frames.size() < n && k < budget) begin
      @(negedge CLOCK_50);
      k++;
    end
    check(tag, 32'(frames.size() >= n), 32'd1);
  endtask

  task automatic wait_done(input int n, input int budget, input string tag);
    int k = 0;
    while (rsp_done < n && k < budget) begin
      @(negedge CLOCK_50);
      k++;
    end
    check(tag, 32'(rsp_done >= n), 32'd1);
  endtask

  task automatic wait_rsp_idle(input int budget, input string tag);
    int k = 0;
    while (rsp_done < frames.size() && k < budget) begin
      @(negedge CLOCK_50);
      k++;
    end
    check(tag, 32'(rsp_done >= frames.size()), 32'd1);
  endtask

  int base, done0, d1, r0, k;

  initial begin
    iRST_N          = 1'b0;
    audio_in_signed = 16'h0000;
    cfg_req         = 1'b0;
    ee_req          = 1'b0;
    pd_mode         = 2'b00;

    // Reset state
    repeat (3) @(negedge CLOCK_50);
    check("rst_go",      32'(i2c_go),      32'd0);
    check("rst_data",    i2c_data,         32'd0);
    check("rst_busy",    32'(busy),        32'd0);
    check("rst_drop",    32'(drop_cnt),    32'd0);
    check("rst_nack",    32'(nack_err),    32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    iRST_N = 1'b1;

    // Sample frames: zero, most negative, most positive
    wait_frames(2, 300, "first_frames");
    check("samp_zero",   frames[1], 32'hC040_8000);
    check("tick_period", 32'(frame_cyc[1] - frame_cyc[0]), 32'd100);

    audio_in_signed = 16'h8000;
    base = frames.size();
    wait_frames(base + 2, 250, "neg_frames");
    check("samp_min", frames[base + 1], 32'hC040_0000);

    audio_in_signed = 16'h7FFF;
    base = frames.size();
    wait_frames(base + 2, 250, "pos_frames");
    check("samp_max", frames[base + 1], 32'hC040_FFF0);

    // NACK: sticky, and the following frame still launches
    wait_rsp_idle(50, "nack_pre_idle");
    rsp_ack = 1'b1;
    wait_done(rsp_done + 1, 150, "nack_frame");
    rsp_ack = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    check("nack_set", 32'(nack_err), 32'd1);
    base = frames.size();
    wait_frames(base + 1, 150, "nack_next_launch");
    wait_done(rsp_done + 1, 50, "nack_next_done");
    check("nack_sticky", 32'(nack_err), 32'd1);

    // Overrun: END held low across three tick periods
    check("drop_before", 32'(drop_cnt), 32'd0);
    rsp_low = 350;
    base = frames.size();
    wait_frames(base + 1, 150, "overrun_frame");
    rsp_low = 3;
    done0 = rsp_done;
    wait_done(done0 + 1, 450, "overrun_end");
    wait_frames(base + 2, 20, "overrun_recover");
    check("overrun_drops", 32'(drop_cnt), 32'd2);
    check("overrun_recover_data", frames[base + 1], 32'hC040_FFF0);
    wait_done(done0 + 2, 30, "overrun_recover_done");
    repeat (10) @(negedge CLOCK_50);
    check("overrun_single", 32'(frames.size()), 32'(base + 2));

    // Priority: cfg_req, ee_req and tick in one cycle
    wait_frames(base + 3, 150, "prio_align");
    r0 = frame_cyc[base + 2];
    k = 0;
    while (cyc < r0 + 98 && k < 200) begin
      @(negedge CLOCK_50);
      k++;
    end
    d1      = int'(drop_cnt);
    cfg_req = 1'b1;
    ee_req  = 1'b1;
    pd_mode = 2'b01;
    @(negedge CLOCK_50);
    cfg_req = 1'b0;
    ee_req  = 1'b0;
    pd_mode = 2'b00;
    wait_frames(base + 6, 500, "prio_frames");
    check("prio_ee_first",   frames[base + 3], 32'hC062_FFF0);
    check("prio_cfg_second", frames[base + 4], 32'hC042_FFF0);
    check("prio_samp_third", frames[base + 5], 32'hC042_FFF0);
    check("ee_wait_lockout",
          32'((frame_cyc[base + 4] - frame_cyc[base + 3] >= 300) &&
              (frame_cyc[base + 4] - frame_cyc[base + 3] <= 330)), 32'd1);
    check("ee_wait_drops", 32'(int'(drop_cnt) - d1), 32'd3);

    // Timeout: END never drops after GO
    wait_rsp_idle(50, "timeout_pre_idle");
    rsp_ignore = 1'b1;
    k = 0;
    while (!timeout_err && k < 800) begin
      @(negedge CLOCK_50);
      k++;
    end
    check("timeout_flag",    32'(timeout_err), 32'd1);
    check("timeout_go_drop", 32'(i2c_go),      32'd0);
    k = 0;
    while (busy && k < 10) begin
      @(negedge CLOCK_50);
      k++;
    end
    check("timeout_idle", 32'(busy), 32'd0);
    rsp_ignore = 1'b0;
    base = frames.size();
    wait_frames(base + 1, 200, "timeout_resume");
    check("timeout_sticky", 32'(timeout_err), 32'd1);

    // Reset mid-RUN clears outputs asynchronously
    wait_rsp_idle(50, "reset_pre_idle");
    rsp_low = 200;
    base = frames.size();
    wait_frames(base + 1, 150, "reset_frame");
    rsp_low = 3;
    repeat (6) @(negedge CLOCK_50);
    check("pre_reset_go", 32'(i2c_go), 32'd1);
    #5 iRST_N = 1'b0;
    #1;
    check("arst_go",      32'(i2c_go),      32'd0);
    check("arst_busy",    32'(busy),        32'd0);
    check("arst_drop",    32'(drop_cnt),    32'd0);
    check("arst_data",    i2c_data,         32'd0);
    check("arst_nack",    32'(nack_err),    32'd0);
    check("arst_timeout", 32'(timeout_err), 32'd0);
    repeat (3) @(negedge CLOCK_50);
    iRST_N = 1'b1;
    wait_frames(base + 2, 400, "post_reset_launch");
    check("post_reset_frame", frames[base + 1], 32'hC040_FFF0);
    check("post_reset_nack",  32'(nack_err),    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
